// File: rtl/vm_pkg.sv
// vm_pkg: shared virtual-memory types for the TLB and its CAM matcher
`ifndef VPN_WIDTH
`define VPN_WIDTH 20
`endif
`ifndef PPN_WIDTH
`define PPN_WIDTH 12
`endif
package vm_pkg;
  localparam int VPN_WIDTH = `VPN_WIDTH;
  localparam int PPN_WIDTH = `PPN_WIDTH;
  localparam int KEY_WIDTH = VPN_WIDTH > PPN_WIDTH ? VPN_WIDTH : PPN_WIDTH;
  typedef enum logic [1:0] {IDLE, LOOKUP, RESP, WAIT_REL} tlb_state_t;
  typedef struct packed {
    logic                 valid;
    logic [VPN_WIDTH-1:0] vpn;
    logic [PPN_WIDTH-1:0] ppn;
  } tlb_entry_t;
endpackage

// File: rtl/defines.sv
// defines: address-field widths shared by the MMU and the TLB
`ifndef VPN_WIDTH
`define VPN_WIDTH 20
`endif
`ifndef PPN_WIDTH
`define PPN_WIDTH 12
`endif

// File: rtl/tlb_cam_match.sv
// tlb_cam_match: combinational associative search over the TLB entries by VPN tag or PPN
module tlb_cam_match
  import vm_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int IW = $clog2(ENTRIES)
) (
  input  tlb_entry_t [ENTRIES-1:0] entries,
  input  logic [KEY_WIDTH-1:0]     key,
  input  logic                     ppn_sel,
  output logic [ENTRIES-1:0]       match,
  output logic                     hit,
  output logic [IW-1:0]            match_idx,
  output logic [IW-1:0]            free_idx
);
  // scan downward so the lowest matching and lowest invalid indices win
  always_comb begin
    match = '0;
    match_idx = '0;
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      match[i] = entries[i].valid && (ppn_sel ? entries[i].ppn == key[PPN_WIDTH-1:0]
                                              : entries[i].vpn == key[VPN_WIDTH-1:0]);
      match_idx = match[i] ? IW'(i) : match_idx;
      free_idx = !entries[i].valid ? IW'(i) : free_idx;
    end
    hit = |match;
  end
endmodule

// File: rtl/tlb.sv
// tlb: fully-associative VPN->PPN cache with fixed-latency lookup, edge-triggered fills and PPN invalidation
module tlb
  import vm_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 translation_request,
  input  logic                 new_entry_request,
  input  logic [VPN_WIDTH-1:0] VPN_in,
  input  logic [PPN_WIDTH-1:0] PPN_in,
  input  logic                 invalidate_request,
  input  logic [PPN_WIDTH-1:0] invalidate_PPN,
  input  logic                 flush,
  output logic                 tlb_ready,
  output logic                 tlb_miss,
  output logic [PPN_WIDTH-1:0] translated_PPN,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);
  localparam int IW = $clog2(ENTRIES);
  tlb_state_t state;
  logic [ENTRIES-1:0] valid;
  logic [VPN_WIDTH-1:0] vpn_tag [ENTRIES];
  logic [PPN_WIDTH-1:0] ppn_tag [ENTRIES];
  tlb_entry_t [ENTRIES-1:0] entries;
  logic [VPN_WIDTH-1:0] vpn_q;
  logic hit_q;
  logic [PPN_WIDTH-1:0] ppn_q;
  logic [IW-1:0] victim_ptr;
  logic fill_prev;
  logic lk_hit, fl_hit;
  logic [IW-1:0] lk_idx, fl_idx, fl_free, fill_idx;
  logic [ENTRIES-1:0] iv_match, lk_match_unused, fl_match_unused;
  logic [IW-1:0] lk_free_unused, iv_idx_unused, iv_free_unused;
  logic iv_hit_unused;
  logic fill, full, victim_fill;
  logic [ENTRIES-1:0] set_vec, clr_vec;
  // flatten the storage into the struct view the matchers consume
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) entries[i] = '{valid[i], vpn_tag[i], ppn_tag[i]};
  end
  // lookup searches the latched VPN against the pre-write array
  tlb_cam_match #(.ENTRIES(ENTRIES)) u_lookup (
    .entries(entries), .key(KEY_WIDTH'(vpn_q)), .ppn_sel(1'b0),
    .match(lk_match_unused), .hit(lk_hit), .match_idx(lk_idx), .free_idx(lk_free_unused)
  );
  // fill needs its own search because a fill edge may coincide with a LOOKUP cycle
  tlb_cam_match #(.ENTRIES(ENTRIES)) u_fill (
    .entries(entries), .key(KEY_WIDTH'(VPN_in)), .ppn_sel(1'b0),
    .match(fl_match_unused), .hit(fl_hit), .match_idx(fl_idx), .free_idx(fl_free)
  );
  tlb_cam_match #(.ENTRIES(ENTRIES)) u_inval (
    .entries(entries), .key(KEY_WIDTH'(invalidate_PPN)), .ppn_sel(1'b1),
    .match(iv_match), .hit(iv_hit_unused), .match_idx(iv_idx_unused), .free_idx(iv_free_unused)
  );
  // pick the fill slot: in-place update, else lowest free, else round-robin victim
  always_comb begin
    fill = new_entry_request && !fill_prev;
    full = &valid;
    fill_idx = fl_hit ? fl_idx : full ? victim_ptr : fl_free;
    victim_fill = fill && !fl_hit && full && !flush;
    set_vec = fill ? ENTRIES'(1) << fill_idx : '0;
    clr_vec = invalidate_request ? iv_match : '0;
  end
  // valid bits and replacement state; flush beats invalidate beats fill
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= '0;
      victim_ptr <= '0;
      fill_prev <= 1'b0;
    end else begin
      fill_prev <= new_entry_request;
      valid <= flush ? '0 : (valid | set_vec) & ~clr_vec;
      victim_ptr <= flush ? '0 : victim_fill ? victim_ptr + IW'(1) : victim_ptr;
    end
  end
  // tag and PPN storage carries no reset; validity alone qualifies it
  always_ff @(posedge clk) begin
    if (fill && !flush) begin
      vpn_tag[fill_idx] <= VPN_in;
      ppn_tag[fill_idx] <= PPN_in;
    end
  end
  // request handshake FSM with registered response and saturating statistics
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      vpn_q <= '0;
      hit_q <= 1'b0;
      ppn_q <= '0;
      tlb_ready <= 1'b0;
      tlb_miss <= 1'b0;
      translated_PPN <= '0;
      hit_count <= '0;
      miss_count <= '0;
    end else begin
      tlb_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (translation_request) begin
            vpn_q <= VPN_in;
            state <= LOOKUP;
          end
        end
        LOOKUP: begin
          hit_q <= lk_hit;
          ppn_q <= lk_hit ? ppn_tag[lk_idx] : '0;
          state <= RESP;
        end
        RESP: begin
          tlb_ready <= 1'b1;
          tlb_miss <= !hit_q;
          translated_PPN <= ppn_q;
          hit_count <= hit_q && !(&hit_count) ? hit_count + CNT_WIDTH'(1) : hit_count;
          miss_count <= !hit_q && !(&miss_count) ? miss_count + CNT_WIDTH'(1) : miss_count;
          state <= WAIT_REL;
        end
        WAIT_REL: state <= !translation_request && !new_entry_request ? IDLE : WAIT_REL;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tlb.sv
// tb_tlb: directed scoreboard bench for the TLB
module tb_tlb;
  import vm_pkg::*;
  typedef struct {
    logic                 miss;
    logic [PPN_WIDTH-1:0] ppn;
    int                   cyc;
  } exp_t;
  logic clk = 0, reset = 1;
  logic translation_request = 0, new_entry_request = 0, invalidate_request = 0, flush = 0;
  logic [VPN_WIDTH-1:0] VPN_in = '0;
  logic [PPN_WIDTH-1:0] PPN_in = '0, invalidate_PPN = '0;
  logic tlb_ready, tlb_miss;
  logic [PPN_WIDTH-1:0] translated_PPN;
  logic [15:0] hit_count, miss_count;
  int cyc = 0, checks = 0, errors = 0;
  exp_t sb[$];

  tlb dut (
    .clk(clk), .reset(reset), .translation_request(translation_request),
    .new_entry_request(new_entry_request), .VPN_in(VPN_in), .PPN_in(PPN_in),
    .invalidate_request(invalidate_request), .invalidate_PPN(invalidate_PPN), .flush(flush),
    .tlb_ready(tlb_ready), .tlb_miss(tlb_miss), .translated_PPN(translated_PPN),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (tlb_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: tlb_ready=1 at cycle %0d, required no response", cyc);
      end else begin
        e = sb.pop_front();
        check("resp_miss", tlb_miss, e.miss);
        check("resp_ppn", translated_PPN, e.ppn);
        check("resp_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic req(input logic [VPN_WIDTH-1:0] vpn, input logic do_fill,
                     input logic [PPN_WIDTH-1:0] fppn, input logic m,
                     input logic [PPN_WIDTH-1:0] p, input int hold);
    bit seen = 0;
    exp_t e;
    @(negedge clk);
    translation_request = 1;
    VPN_in = vpn;
    if (do_fill) begin
      new_entry_request = 1;
      PPN_in = fppn;
    end
    @(posedge clk);
    #1;
    e.miss = m;
    e.ppn = p;
    e.cyc = cyc + 2;
    sb.push_back(e);
    @(negedge clk);
    new_entry_request = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      seen = tlb_ready;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: no tlb_ready for VPN %0d, required one within 2 cycles", vpn);
    end
    repeat (hold) @(negedge clk);
    translation_request = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic fill(input logic [VPN_WIDTH-1:0] vpn, input logic [PPN_WIDTH-1:0] ppn, input int hold);
    @(negedge clk);
    new_entry_request = 1;
    VPN_in = vpn;
    PPN_in = ppn;
    repeat (hold) @(negedge clk);
    new_entry_request = 0;
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
  endtask

  task automatic do_inval(input logic [PPN_WIDTH-1:0] ppn);
    @(negedge clk);
    invalidate_request = 1;
    invalidate_PPN = ppn;
    @(negedge clk);
    invalidate_request = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    #1 reset = 0;
    repeat (3) @(negedge clk);
    reset = 1;
    @(negedge clk);
    check("rst_ready", tlb_ready, 0);
    check("rst_miss", tlb_miss, 0);
    check("rst_ppn", translated_PPN, 0);
    check("rst_hits", hit_count, 0);
    check("rst_misses", miss_count, 0);
    check("rst_valid", $countones(dut.valid), 0);

    req(12, 0, 0, 1, 0, 0);
    check("first_miss_count", miss_count, 1);
    check("first_hit_count", hit_count, 0);

    fill(12, 3, 10);
    check("long_fill_one_entry", $countones(dut.valid), 1);
    req(12, 0, 0, 0, 3, 0);
    check("hit_count_1", hit_count, 1);

    do_flush();
    for (int i = 0; i < 8; i++) fill(i, i, 1);
    check("array_full", $countones(dut.valid), 8);
    fill(9, 9, 1);
    req(0, 0, 0, 1, 0, 0);
    req(9, 0, 0, 0, 9, 0);
    fill(10, 10, 1);
    req(1, 0, 0, 1, 0, 0);
    req(2, 0, 0, 0, 2, 0);

    do_flush();
    check("flush_clears", $countones(dut.valid), 0);
    req(9, 0, 0, 1, 0, 0);
    fill(12, 3, 1);
    fill(20, 3, 1);
    fill(4, 4, 1);
    check("pre_inval_count", $countones(dut.valid), 3);
    do_inval(3);
    check("post_inval_count", $countones(dut.valid), 1);
    req(12, 0, 0, 1, 0, 0);
    req(20, 0, 0, 1, 0, 0);
    req(4, 0, 0, 0, 4, 0);

    do_flush();
    req(5, 1, 2, 0, 2, 3);
    check("hits_before_reset", hit_count, 5);
    check("misses_before_reset", miss_count, 6);

    @(negedge clk);
    translation_request = 1;
    VPN_in = 5;
    @(posedge clk);
    #2;
    reset = 0;
    #1;
    check("async_rst_ready", tlb_ready, 0);
    check("async_rst_valid", $countones(dut.valid), 0);
    check("async_rst_hits", hit_count, 0);
    translation_request = 0;
    repeat (4) @(negedge clk);
    check("held_rst_ready", tlb_ready, 0);
    reset = 1;
    @(negedge clk);
    req(5, 0, 0, 1, 0, 0);
    check("post_rst_misses", miss_count, 1);
    check("post_rst_hits", hit_count, 0);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
